// File: rtl/riscv_fetch_aligner.sv
// Fetch-stage aligner: buffers word fetches as halfwords and presents one
// complete 16- or 32-bit RISC-V instruction per cycle to the decode register.
module riscv_fetch_aligner #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          QDEPTH_HW = 4
) (
  input  logic        i_riscv_align_clk,
  input  logic        i_riscv_align_rst,
  input  logic        i_riscv_align_flush,
  input  logic [63:0] i_riscv_align_redirect_pc,
  input  logic        i_riscv_align_stall,
  output logic        o_riscv_align_fetch_req,
  output logic [63:0] o_riscv_align_fetch_addr,
  input  logic        i_riscv_align_fetch_ack,
  input  logic [31:0] i_riscv_align_fetch_data,
  output logic        o_riscv_align_valid,
  output logic [63:0] o_riscv_align_pc_f,
  output logic [31:0] o_riscv_align_inst_f,
  output logic [15:0] o_riscv_align_cinst_f,
  output logic        o_riscv_align_is_c_f,
  output logic [63:0] o_riscv_align_pcplus4_f
);

  localparam int PW = $clog2(QDEPTH_HW);
  localparam int CW = $clog2(QDEPTH_HW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REQ_DROP
  } state_t;

  state_t        state;
  logic [15:0]   queue [QDEPTH_HW];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [63:0]   issue_pc;
  logic [63:0]   fetch_addr;
  logic [63:0]   target_addr;
  logic          skip_lo;

  logic [15:0]   hw0;
  logic [15:0]   hw1;
  logic          head_c;
  logic          valid;
  logic          consume;
  logic          push;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] push_n;
  logic [CW-1:0] count_after_pop;
  logic [63:0]   redirect_hw;
  logic [63:0]   redirect_word;

  assign hw0    = queue[head];
  assign hw1    = queue[head + PW'(1)];
  assign head_c = (hw0[1:0] != 2'b11);
  assign valid  = ((count >= CW'(1)) && head_c) || (count >= CW'(2));

  assign consume         = valid && !i_riscv_align_stall && !i_riscv_align_flush;
  assign pop_n           = consume ? (head_c ? CW'(1) : CW'(2)) : CW'(0);
  assign count_after_pop = count - pop_n;

  // Data arriving alongside a flush belongs to the old stream and is dropped.
  assign push   = (state == S_REQ) && i_riscv_align_fetch_ack && !i_riscv_align_flush;
  assign push_n = push ? (skip_lo ? CW'(1) : CW'(2)) : CW'(0);

  assign redirect_hw   = i_riscv_align_redirect_pc & ~64'd1;
  assign redirect_word = i_riscv_align_redirect_pc & ~64'd3;

  // NOTE: queue storage has no reset; count alone decides which entries are live.
  always_ff @(posedge i_riscv_align_clk) begin
    if (push) begin
      if (skip_lo) begin
        queue[tail] <= i_riscv_align_fetch_data[31:16];
      end else begin
        queue[tail]          <= i_riscv_align_fetch_data[15:0];
        queue[tail + PW'(1)] <= i_riscv_align_fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge i_riscv_align_clk) begin
    if (i_riscv_align_rst) begin
      state       <= S_IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      issue_pc    <= RESET_PC & ~64'd1;
      fetch_addr  <= RESET_PC & ~64'd3;
      target_addr <= RESET_PC & ~64'd3;
      skip_lo     <= RESET_PC[1];
    end else if (i_riscv_align_flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      issue_pc <= redirect_hw;
      skip_lo  <= i_riscv_align_redirect_pc[1];
      // An unanswered request must be retired before the new address goes out.
      if (state == S_IDLE || i_riscv_align_fetch_ack) begin
        fetch_addr <= redirect_word;
        state      <= S_IDLE;
      end else begin
        target_addr <= redirect_word;
        state       <= S_REQ_DROP;
      end
    end else begin
      head     <= head + PW'(pop_n);
      tail     <= tail + PW'(push_n);
      count    <= count + push_n - pop_n;
      issue_pc <= issue_pc + (consume ? (head_c ? 64'd2 : 64'd4) : 64'd0);
      if (push) begin
        skip_lo <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (count_after_pop <= CW'(QDEPTH_HW - 2)) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_riscv_align_fetch_ack) begin
            fetch_addr <= fetch_addr + 64'd4;
            state      <= S_IDLE;
          end
        end
        S_REQ_DROP: begin
          if (i_riscv_align_fetch_ack) begin
            fetch_addr <= target_addr;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_riscv_align_fetch_req  = (state != S_IDLE);
  assign o_riscv_align_fetch_addr = fetch_addr;
  assign o_riscv_align_valid      = valid;

  always_comb begin
    o_riscv_align_pc_f      = '0;
    o_riscv_align_inst_f    = '0;
    o_riscv_align_cinst_f   = '0;
    o_riscv_align_is_c_f    = 1'b0;
    o_riscv_align_pcplus4_f = '0;
    if (valid) begin
      o_riscv_align_pc_f   = issue_pc;
      o_riscv_align_is_c_f = head_c;
      if (head_c) begin
        o_riscv_align_inst_f    = {16'h0, hw0};
        o_riscv_align_cinst_f   = hw0;
        o_riscv_align_pcplus4_f = issue_pc + 64'd2;
      end else begin
        o_riscv_align_inst_f    = {hw1, hw0};
        o_riscv_align_pcplus4_f = issue_pc + 64'd4;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_aligner.sv
// Directed self-checking bench for riscv_fetch_aligner; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_riscv_fetch_aligner;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        valid;
  logic [63:0] pc_f;
  logic [31:0] inst_f;
  logic [15:0] cinst_f;
  logic        is_c_f;
  logic [63:0] pcplus4_f;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_fetch_aligner #(
    .RESET_PC  (64'h0),
    .QDEPTH_HW (4)
  ) dut (
    .i_riscv_align_clk         (clk),
    .i_riscv_align_rst         (rst),
    .i_riscv_align_flush       (flush),
    .i_riscv_align_redirect_pc (redirect_pc),
    .i_riscv_align_stall       (stall),
    .o_riscv_align_fetch_req   (fetch_req),
    .o_riscv_align_fetch_addr  (fetch_addr),
    .i_riscv_align_fetch_ack   (fetch_ack),
    .i_riscv_align_fetch_data  (fetch_data),
    .o_riscv_align_valid       (valid),
    .o_riscv_align_pc_f        (pc_f),
    .o_riscv_align_inst_f      (inst_f),
    .o_riscv_align_cinst_f     (cinst_f),
    .o_riscv_align_is_c_f      (is_c_f),
    .o_riscv_align_pcplus4_f   (pcplus4_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    redirect_pc = '0;
    stall       = 1'b1;
    fetch_ack   = 1'b0;
    fetch_data  = '0;
    tick();
    tick();
    check("rst_valid",   64'(valid),     64'd0);
    check("rst_req",     64'(fetch_req), 64'd0);
    check("rst_addr",    fetch_addr,     64'd0);
    check("rst_pc",      pc_f,           64'd0);
    check("rst_pcplus4", pcplus4_f,      64'd0);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a request, check its address, then answer it for one cycle.
  task automatic serve(input logic [31:0] d, input logic [63:0] exp_addr, input string tag);
    int n = 0;
    while (!fetch_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"},  64'(fetch_req), 64'd1);
    check({tag, "_addr"}, fetch_addr,     exp_addr);
    fetch_ack  = 1'b1;
    fetch_data = d;
    tick();
    fetch_ack  = 1'b0;
    fetch_data = '0;
  endtask

  task automatic consume_one();
    stall = 1'b0;
    tick();
    stall = 1'b1;
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    redirect_pc = '0;
    stall       = 1'b1;
    fetch_ack   = 1'b0;
    fetch_data  = '0;
    @(negedge clk);

    // 32-bit instruction in a single aligned word
    do_reset();
    serve(32'h0050_0093, 64'h0, "t1");
    check("t1_valid",   64'(valid),  64'd1);
    check("t1_pc",      pc_f,        64'h0);
    check("t1_inst",    64'(inst_f), 64'h0050_0093);
    check("t1_is_c",    64'(is_c_f), 64'd0);
    check("t1_cinst",   64'(cinst_f), 64'd0);
    check("t1_pcplus4", pcplus4_f,   64'h4);

    // Two compressed instructions in one word
    do_reset();
    serve(32'h4505_0001, 64'h0, "t2");
    check("t2a_pc",      pc_f,         64'h0);
    check("t2a_is_c",    64'(is_c_f),  64'd1);
    check("t2a_cinst",   64'(cinst_f), 64'h0001);
    check("t2a_pcplus4", pcplus4_f,    64'h2);
    consume_one();
    check("t2b_pc",      pc_f,         64'h2);
    check("t2b_cinst",   64'(cinst_f), 64'h4505);
    check("t2b_inst",    64'(inst_f),  64'h0000_4505);
    check("t2b_pcplus4", pcplus4_f,    64'h4);

    // 32-bit instruction spanning a word boundary
    do_reset();
    serve(32'h0093_0001, 64'h0, "t3");
    check("t3a_pc",    pc_f,         64'h0);
    check("t3a_cinst", 64'(cinst_f), 64'h0001);
    consume_one();
    check("t3_half_valid", 64'(valid), 64'd0);
    serve(32'h1234_0050, 64'h4, "t3b");
    check("t3b_valid",   64'(valid),  64'd1);
    check("t3b_pc",      pc_f,        64'h2);
    check("t3b_inst",    64'(inst_f), 64'h0050_0093);
    check("t3b_pcplus4", pcplus4_f,   64'h6);
    consume_one();
    check("t3c_pc",      pc_f,         64'h6);
    check("t3c_cinst",   64'(cinst_f), 64'h1234);
    check("t3c_pcplus4", pcplus4_f,    64'h8);

    // Redirect to a halfword-aligned target; first word supplies only its upper half
    do_reset();
    flush       = 1'b1;
    redirect_pc = 64'h102;
    tick();
    flush = 1'b0;
    serve(32'h0093_0001, 64'h100, "t4");
    check("t4_half_valid", 64'(valid), 64'd0);
    serve(32'h1234_0050, 64'h104, "t4b");
    check("t4_pc",      pc_f,        64'h102);
    check("t4_inst",    64'(inst_f), 64'h0050_0093);
    check("t4_pcplus4", pcplus4_f,   64'h106);

    // Flush while a request is outstanding; the late data must be dropped
    do_reset();
    tick();
    check("t5_req0", 64'(fetch_req), 64'd1);
    flush       = 1'b1;
    redirect_pc = 64'h200;
    tick();
    flush = 1'b0;
    check("t5_hold_req",  64'(fetch_req), 64'd1);
    check("t5_hold_addr", fetch_addr,     64'h0);
    tick();
    tick();
    fetch_ack  = 1'b1;
    fetch_data = 32'h0050_0093;
    tick();
    fetch_ack  = 1'b0;
    fetch_data = '0;
    check("t5_drop_valid", 64'(valid),  64'd0);
    check("t5_drop_inst",  64'(inst_f), 64'd0);
    serve(32'h4505_0001, 64'h200, "t5b");
    check("t5_pc",    pc_f,         64'h200);
    check("t5_cinst", 64'(cinst_f), 64'h0001);

    // Stall with a full queue, then drain
    do_reset();
    serve(32'h0000_0001, 64'h0, "t6a");
    serve(32'h0000_0001, 64'h4, "t6b");
    for (int i = 0; i < 5; i++) begin
      check("t6_stall_pc",    pc_f,            64'h0);
      check("t6_stall_inst",  64'(inst_f),     64'h1);
      check("t6_stall_req",   64'(fetch_req),  64'd0);
      check("t6_stall_valid", 64'(valid),      64'd1);
      tick();
    end
    stall = 1'b0;
    tick();
    check("t6_d1_pc",  pc_f,            64'h2);
    check("t6_d1_req", 64'(fetch_req),  64'd0);
    tick();
    check("t6_d2_pc",   pc_f,           64'h4);
    check("t6_d2_req",  64'(fetch_req), 64'd1);
    check("t6_d2_addr", fetch_addr,     64'h8);
    tick();
    check("t6_d3_pc", pc_f, 64'h6);
    tick();
    check("t6_empty_valid", 64'(valid), 64'd0);
    check("t6_empty_pc",    pc_f,       64'h0);
    stall = 1'b1;

    // Address wrap at the top of the 64-bit space
    do_reset();
    flush       = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    flush = 1'b0;
    serve(32'h0001_0000, 64'hFFFF_FFFF_FFFF_FFFC, "t7");
    check("t7_pc",      pc_f,         64'hFFFF_FFFF_FFFF_FFFE);
    check("t7_cinst",   64'(cinst_f), 64'h0001);
    check("t7_pcplus4", pcplus4_f,    64'h0);
    serve(32'h0000_0001, 64'h0, "t7b");
    consume_one();
    check("t7b_pc",    pc_f,         64'h0);
    check("t7b_valid", 64'(valid),   64'd1);
    check("t7b_cinst", 64'(cinst_f), 64'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
